hack_write_dispatcher: RTL
==========================

// Module: hack_write_dispatcher
// PURPOSE
//  Sequences CPU data-memory writes (addressM/outM/writeM stream) onto the Hack memory map.
//  Buffers writes in a small in-order FIFO, decodes each address and steers the load strobe
//  to RAM16K (single-cycle, always ready) or to the screen controller (valid/ready, may stall).
//  Writes to the keyboard word or above are dropped and counted. Sits between CPU and Memory.
// PARAMETERS
//  FIFO_DEPTH   4       write-buffer entries; power of 2, >=2
//  SCREEN_BASE  16384   first screen address (0x4000)
//  KBD_ADDR     24576   keyboard address (0x6000); any addr >= this is illegal for writes
// PORTS
//  clk        in   1   system clock, rising edge
//  reset      in   1   asynchronous, active-high; clears all state
//  in_valid   in   1   write request present
//  in_ready   out  1   FIFO can accept; transfer when in_valid & in_ready
//  in_addr    in   15  write address
//  in_data    in   16  write data
//  ram_load   out  1   one-cycle RAM write strobe
//  ram_addr   out  14  RAM address, valid while ram_load=1
//  ram_data   out  16  RAM data, valid while ram_load=1
//  scr_valid  out  1   screen write request
//  scr_ready  in   1   screen accepts; transfer when scr_valid & scr_ready
//  scr_addr   out  13  in_addr - SCREEN_BASE
//  scr_data   out  16  screen data
//  err_pulse  out  1   one-cycle pulse per dropped illegal write
//  err_count  out  8   saturating count of dropped writes
//  busy       out  1   FIFO non-empty or a dispatch in progress
// BEHAVIOUR
//  Reset (async): FIFO empty, state IDLE; ram_load=0, scr_valid=0, err_pulse=0, err_count=0,
//   busy=0, in_ready=1; ram_*/scr_* addr/data = 0. Reset mid-transfer aborts it; no retry.
//  Ordering: strictly in-order. A stalled screen write blocks all later writes, incl. RAM.
//  in_ready = !full. No push-on-pop bypass when full: a full FIFO refuses input even if
//   it pops that cycle. A push into an empty FIFO cannot be popped until the next edge.
//  Decode of FIFO head: addr < SCREEN_BASE -> RAM; SCREEN_BASE <= addr < KBD_ADDR -> SCREEN;
//   otherwise DROP.
//  FSM (registered outputs):
//   IDLE: if head valid, pop it. RAM -> RAM_WR; SCREEN -> SCR_WAIT; DROP -> DROP.
//   RAM_WR: ram_load=1 for exactly this cycle. If next head valid, pop and branch as IDLE.
//     Else -> IDLE. Back-to-back RAM writes therefore sustain 1 per clock.
//   SCR_WAIT: scr_valid=1; addr/data held stable until scr_ready=1. On transfer, pop next
//     head as in IDLE, or -> IDLE. scr_valid never drops without a transfer (reset excepted).
//   DROP: err_pulse=1 this cycle; err_count+=1, saturating at 255. Then as RAM_WR exit.
//  Latency: a write accepted in cycle 0 into an empty, idle block produces ram_load
//   (or first scr_valid, or err_pulse) in cycle 2.
//  busy = !empty | (state != IDLE).
//  Boundary addresses: 16383 -> RAM addr 16383; 16384 -> scr_addr 0; 24575 -> scr_addr
//   8191; 24576 and 32767 -> DROP.
//  FIFO pointers wrap modulo FIFO_DEPTH. Use a count register for full/empty detection.
// TESTING
//  1 RAM burst: 6 writes to addr 0..5, one per cycle, data 0xA000+i -> ram_load high 6
//    consecutive cycles, first in cycle 2; ram_addr/data match in order; in_ready drops
//    only if the FIFO fills.
//  2 Screen stall: write 0x4000/0x1234, scr_ready=0 for 10 cycles, then 1 -> scr_valid holds
//    scr_addr=0, data=0x1234 stable throughout; single transfer; busy=0 after.
//  3 Ordering/backpressure: screen write (stalled) then 5 RAM writes -> in_ready=0 once 4
//    are buffered; no ram_load until the screen transfer; all RAM writes then issue in order.
//  4 Illegal: writes to 24576, 32767, 24575 -> err_pulse twice, err_count=2; 24575 reaches
//    the screen as scr_addr=8191. Drive 300 illegal writes -> err_count saturates at 255.
//  5 Reset mid-op: assert reset while scr_valid=1 with 3 entries queued -> scr_valid,
//    ram_load and busy go 0 immediately (asynchronously); in_ready=1; after release no
//    queued write is issued.

Source files
------------

// File: rtl/hack_write_dispatcher_if.sv
// Purpose : bundles the CPU write stream, the RAM16K load port, the screen
//           valid/ready port and the status outputs of hack_write_dispatcher.
// Ports   : master = CPU/system side (drives requests and scr_ready),
//           slave  = the dispatcher (accepts requests, drives memory strobes).
interface hack_write_dispatcher_if;
  // CPU write request stream
  logic        in_valid;
  logic        in_ready;
  logic [14:0] in_addr;
  logic [15:0] in_data;
  // RAM16K load port (single cycle, always accepts)
  logic        ram_load;
  logic [13:0] ram_addr;
  logic [15:0] ram_data;
  // screen controller port (valid/ready, may stall)
  logic        scr_valid;
  logic        scr_ready;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  // status
  logic        err_pulse;
  logic [7:0]  err_count;
  logic        busy;

  modport master (
    output in_valid, in_addr, in_data, scr_ready,
    input  in_ready, ram_load, ram_addr, ram_data,
    input  scr_valid, scr_addr, scr_data, err_pulse, err_count, busy
  );

  modport slave (
    input  in_valid, in_addr, in_data, scr_ready,
    output in_ready, ram_load, ram_addr, ram_data,
    output scr_valid, scr_addr, scr_data, err_pulse, err_count, busy
  );
endinterface

// File: rtl/hack_write_dispatcher.sv
// Purpose : buffers CPU data-memory writes in an in-order FIFO and steers each
//           one to RAM16K, the screen controller, or drops it (keyboard and up).
// Ports   : clk, reset (async, active-high); bus (slave modport) carries the
//           in_* request stream, ram_* strobe, scr_* handshake and err/busy status.
// Latency : write accepted in cycle 0 into an idle block is dispatched in cycle 2;
//           back-to-back RAM writes sustain one per clock.
// Backpr. : in_ready = !full; a stalled screen write holds every later write.
module hack_write_dispatcher #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [14:0] SCREEN_BASE = 15'd16384,
  parameter logic [14:0] KBD_ADDR    = 15'd24576
) (
  input logic                  clk,
  input logic                  reset,
  hack_write_dispatcher_if.slave bus
);

  localparam int unsigned      PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  typedef struct packed {
    logic [14:0] addr;
    logic [15:0] data;
  } wr_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    RAM_WR,
    SCR_WAIT,
    DROP
  } state_t;

  typedef enum logic [1:0] {
    DST_RAM,
    DST_SCR,
    DST_DROP
  } dest_t;

  // ---------------------------------------------------------------------------
  // Write buffer
  // ---------------------------------------------------------------------------
  wr_entry_t        mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic      full;
  logic      empty;
  logic      push;
  logic      pop;
  wr_entry_t head;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);

  // No bypass: readiness depends only on the registered count, so a full
  // buffer refuses input even on a cycle where it also pops.
  assign bus.in_ready = !full;
  assign push         = bus.in_valid & !full;
  assign head         = mem[rd_ptr];

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{addr: bus.in_addr, data: bus.in_data};
    end
  end

  // Pointers wrap naturally since FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Head decode
  // ---------------------------------------------------------------------------
  dest_t       head_dest;
  logic [12:0] scr_off;

  always_comb begin
    head_dest = DST_DROP;
    if (head.addr < SCREEN_BASE) begin
      head_dest = DST_RAM;
    end else if (head.addr < KBD_ADDR) begin
      head_dest = DST_SCR;
    end
  end

  // Screen window is 8K words, so the offset only needs the low 13 bits.
  assign scr_off = head.addr[12:0] - SCREEN_BASE[12:0];

  // ---------------------------------------------------------------------------
  // Dispatch FSM (all outputs registered)
  // ---------------------------------------------------------------------------
  state_t      state;
  logic        ram_load_q;
  logic [13:0] ram_addr_q;
  logic [15:0] ram_data_q;
  logic        scr_valid_q;
  logic [12:0] scr_addr_q;
  logic [15:0] scr_data_q;
  logic        err_pulse_q;
  logic [7:0]  err_count_q;
  logic        advance;

  // Every state other than a stalled screen write finishes in one cycle, so
  // the FSM may take the next head unless the screen is still refusing.
  assign advance = (state != SCR_WAIT) | bus.scr_ready;
  assign pop     = advance & !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ram_load_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      scr_valid_q <= 1'b0;
      scr_addr_q  <= '0;
      scr_data_q  <= '0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      ram_load_q  <= 1'b0;
      err_pulse_q <= 1'b0;
      if (advance) begin
        // scr_valid only falls here, i.e. after a completed transfer.
        scr_valid_q <= 1'b0;
        state       <= IDLE;
        if (!empty) begin
          case (head_dest)
            DST_RAM: begin
              state      <= RAM_WR;
              ram_load_q <= 1'b1;
              ram_addr_q <= head.addr[13:0];
              ram_data_q <= head.data;
            end
            DST_SCR: begin
              state       <= SCR_WAIT;
              scr_valid_q <= 1'b1;
              scr_addr_q  <= scr_off;
              scr_data_q  <= head.data;
            end
            default: begin
              state       <= DROP;
              err_pulse_q <= 1'b1;
              if (err_count_q != 8'hFF) begin
                err_count_q <= err_count_q + 8'd1;
              end
            end
          endcase
        end
      end
    end
  end

  assign bus.ram_load  = ram_load_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_data  = ram_data_q;
  assign bus.scr_valid = scr_valid_q;
  assign bus.scr_addr  = scr_addr_q;
  assign bus.scr_data  = scr_data_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;
  assign bus.busy      = !empty | (state != IDLE);

endmodule
